dir_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the adventure-game FSM. Drives its n/s/e/w move inputs.
- Takes four raw, asynchronous, bouncy push-button levels and synchronises and debounces each one.
- Converts each accepted press into exactly one single-cycle, one-hot direction pulse, which the game consumes as one move on one clock edge.
- Also blocks moves once the game reports death or win, and keeps a saturating count of accepted moves.

---
 rtl/dir_input_conditioner.sv | 117 +++++++++++
 tb/tb_dir_input_conditioner.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_input_conditioner.sv
// rtl/dir_input_conditioner.sv - synchronise, debounce and one-shot four direction buttons for the game FSM
module dir_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_n,
    input  logic               btn_s,
    input  logic               btn_e,
    input  logic               btn_w,
    input  logic               game_over,
    output logic               n,
    output logic               s,
    output logic               e,
    output logic               w,
    output logic               conflict,
    output logic [COUNT_W-1:0] move_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value one short of DEBOUNCE_CYCLES: the next mismatch completes the debounce window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;

    // Bit order shared by every per-button vector: 0 = north, 1 = south, 2 = east, 3 = west.
    logic [3:0] btn;
    logic [3:0] synced;
    logic [3:0] deb;

    assign btn = {btn_w, btn_e, btn_s, btn_n};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CNT_W-1:0]       cnt_q;
            logic                   deb_q;

            // Shift the raw asynchronous level through the synchroniser chain.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], btn[i]};
                end
            end

            assign synced[i] = sync_q[SYNC_STAGES-1];

            // Flip the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else if (synced[i] == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    deb_q <= synced[i];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            assign deb[i] = deb_q;
        end
    endgenerate

    logic       any_pressed;
    logic       multi_pressed;
    logic [0:0] state;
    logic [3:0] dir_q;
    logic       conflict_q;

    assign any_pressed   = |deb;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_pressed = (deb & (deb - 4'd1)) != 4'd0;

    // Accept at most one move per press-and-release episode; pulses and conflict last one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dir_q      <= 4'd0;
            conflict_q <= 1'b0;
            move_count <= '0;
        end else begin
            dir_q      <= 4'd0;
            conflict_q <= 1'b0;
            if (state == IDLE) begin
                if (any_pressed) begin
                    state <= HELD;
                    if (multi_pressed) begin
                        conflict_q <= 1'b1;
                    end else if (!game_over) begin
                        dir_q <= deb;
                        if (move_count != {COUNT_W{1'b1}}) begin
                            move_count <= move_count + COUNT_W'(1);
                        end
                    end
                end
            end else if (!any_pressed) begin
                state <= IDLE;
            end
        end
    end

    assign n        = dir_q[0];
    assign s        = dir_q[1];
    assign e        = dir_q[2];
    assign w        = dir_q[3];
    assign conflict = conflict_q;

endmodule

// File: tb/tb_dir_input_conditioner.sv
// tb/tb_dir_input_conditioner.sv - self-checking bench for dir_input_conditioner
module tb_dir_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_n = 1'b0;
    logic       btn_s = 1'b0;
    logic       btn_e = 1'b0;
    logic       btn_w = 1'b0;
    logic       game_over = 1'b0;

    logic       n, s, e, w, conflict;
    logic [7:0] move_count;
    logic       n2, s2, e2, w2, conflict2;
    logic [1:0] move_count2;

    int n_checks = 0;
    int n_fail   = 0;
    int ec       = 0;

    always #5 clk = ~clk;

    dir_input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .COUNT_W(8)) dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
        .game_over(game_over), .n(n), .s(s), .e(e), .w(w), .conflict(conflict),
        .move_count(move_count)
    );

    dir_input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
        .game_over(game_over), .n(n2), .s(s2), .e(e2), .w(w2), .conflict(conflict2),
        .move_count(move_count2)
    );

    // Reference model: raw history delayed by the synchroniser depth, a debounced level that
    // flips when the last DEB synchronised samples all disagree with it, and one move per episode.
    logic [3:0]  raw_hist[$];
    logic [3:0]  sync_hist[$];
    logic [3:0]  m_deb = 4'd0;
    logic [3:0]  m_pulse = 4'd0;
    logic        m_conf = 1'b0;
    bit          m_held = 1'b0;
    int unsigned m_acc = 0;
    logic [3:0]  sv, nd;
    bit          alld;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                raw_hist = {};
                sync_hist = {};
                m_deb = 4'd0;
                m_pulse = 4'd0;
                m_conf = 1'b0;
                m_held = 1'b0;
                m_acc = 0;
                ec = 0;
            end else begin
                ec++;
                m_pulse = 4'd0;
                m_conf = 1'b0;
                if (!m_held && m_deb != 4'd0) begin
                    m_held = 1'b1;
                    if ($countones(m_deb) > 1) m_conf = 1'b1;
                    else if (!game_over) begin
                        m_pulse = m_deb;
                        m_acc++;
                    end
                end else if (m_held && m_deb == 4'd0) begin
                    m_held = 1'b0;
                end
                sv = (raw_hist.size() >= SYNC) ? raw_hist[SYNC-1] : 4'd0;
                raw_hist.push_front({btn_w, btn_e, btn_s, btn_n});
                if (raw_hist.size() > SYNC) void'(raw_hist.pop_back());
                sync_hist.push_front(sv);
                if (sync_hist.size() > DEB) void'(sync_hist.pop_back());
                nd = m_deb;
                for (int b = 0; b < 4; b++) begin
                    alld = (sync_hist.size() == DEB);
                    foreach (sync_hist[j]) if (sync_hist[j][b] == m_deb[b]) alld = 1'b0;
                    if (alld) nd[b] = ~m_deb[b];
                end
                m_deb = nd;
            end
        end
    end

    logic [19:0] obs, expv;
    logic [7:0]  mc_exp;
    logic [1:0]  mc2_exp;
    assign mc_exp  = (m_acc > 255) ? 8'hFF : 8'(m_acc);
    assign mc2_exp = (m_acc > 3) ? 2'd3 : 2'(m_acc);
    assign obs  = {n, s, e, w, conflict, move_count, n2, s2, e2, w2, conflict2, move_count2};
    assign expv = {m_pulse[0], m_pulse[1], m_pulse[2], m_pulse[3], m_conf, mc_exp,
                   m_pulse[0], m_pulse[1], m_pulse[2], m_pulse[3], m_conf, mc2_exp};

    task automatic apply_reset();
        reset = 1'b1;
        {btn_w, btn_e, btn_s, btn_n} = 4'd0;
        game_over = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs actual=%h required=0", obs);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 20'd0) begin
                n_fail++;
                $display("FAIL idle_after_reset ec=%0d actual=%h required=0", ec, obs);
            end
        end
    endtask

    task automatic test_north_latency();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL north_model ec=%0d actual=%h required=%h", ec, obs, expv);
            end
            n_checks++;
            if ({n, s, e, w, conflict} !== {(ec == 17), 4'b0000}) begin
                n_fail++;
                $display("FAIL north_pulse ec=%0d actual=%b required=%b", ec,
                         {n, s, e, w, conflict}, {(ec == 17), 4'b0000});
            end
            if (ec == 10) btn_n = 1'b1;
        end
        n_checks++;
        if (move_count !== 8'd1) begin
            n_fail++;
            $display("FAIL north_count actual=%0d required=1", move_count);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL bounce_model ec=%0d actual=%h required=%h", ec, obs, expv);
            end
            n_checks++;
            if (e !== (ec == 16)) begin
                n_fail++;
                $display("FAIL bounce_pulse ec=%0d actual=%b required=%b", ec, e, (ec == 16));
            end
            if (ec >= 5 && ec <= 9) btn_e = (ec % 2 == 1);
        end
        n_checks++;
        if (move_count !== 8'd1) begin
            n_fail++;
            $display("FAIL bounce_count actual=%0d required=1", move_count);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL conflict_model ec=%0d actual=%h required=%h", ec, obs, expv);
            end
            n_checks++;
            if ({conflict, s, w} !== {(ec == 12), 1'b0, (ec == 42)}) begin
                n_fail++;
                $display("FAIL conflict_flags ec=%0d actual=%b required=%b", ec,
                         {conflict, s, w}, {(ec == 12), 1'b0, (ec == 42)});
            end
            if (ec == 5)  begin btn_s = 1'b1; btn_w = 1'b1; end
            if (ec == 20) begin btn_s = 1'b0; btn_w = 1'b0; end
            if (ec == 35) btn_w = 1'b1;
        end
        n_checks++;
        if (move_count !== 8'd1) begin
            n_fail++;
            $display("FAIL conflict_count actual=%0d required=1", move_count);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c < 75; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL seq_model ec=%0d actual=%h required=%h", ec, obs, expv);
            end
            n_checks++;
            if ({n, e, w} !== {(ec == 12), (ec == 36), (ec == 60)}) begin
                n_fail++;
                $display("FAIL seq_pulses ec=%0d actual=%b required=%b", ec,
                         {n, e, w}, {(ec == 12), (ec == 36), (ec == 60)});
            end
            if (ec == 5)  btn_n = 1'b1;
            if (ec == 17) btn_n = 1'b0;
            if (ec == 29) btn_e = 1'b1;
            if (ec == 41) btn_e = 1'b0;
            if (ec == 53) btn_w = 1'b1;
            if (ec == 65) btn_w = 1'b0;
        end
        n_checks++;
        if (move_count !== 8'd3) begin
            n_fail++;
            $display("FAIL seq_count actual=%0d required=3", move_count);
        end
    endtask

    task automatic test_game_over();
        apply_reset();
        for (int c = 0; c < 55; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL gameover_model ec=%0d actual=%h required=%h", ec, obs, expv);
            end
            n_checks++;
            if (s !== (ec == 47)) begin
                n_fail++;
                $display("FAIL gameover_pulse ec=%0d actual=%b required=%b", ec, s, (ec == 47));
            end
            if (ec == 2)  game_over = 1'b1;
            if (ec == 5)  btn_s = 1'b1;
            if (ec == 20) game_over = 1'b0;
            if (ec == 22) btn_s = 1'b0;
            if (ec == 40) btn_s = 1'b1;
        end
        n_checks++;
        if (move_count !== 8'd1) begin
            n_fail++;
            $display("FAIL gameover_count actual=%0d required=1", move_count);
        end
    endtask

    task automatic test_saturation_and_reset();
        int sat_exp[6] = '{1, 2, 3, 3, 3, 3};
        int j;
        apply_reset();
        for (int c = 0; c < 135; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL sat_model ec=%0d actual=%h required=%h", ec, obs, expv);
            end
            if (ec >= 14 && (ec - 14) % 20 == 0 && (ec - 14) / 20 < 6) begin
                j = (ec - 14) / 20;
                n_checks++;
                if ({move_count2, move_count} !== {2'(sat_exp[j]), 8'(j + 1)}) begin
                    n_fail++;
                    $display("FAIL sat_count press=%0d actual=%0d/%0d required=%0d/%0d", j,
                             move_count2, move_count, sat_exp[j], j + 1);
                end
            end
            if (ec < 125 && ec % 20 == 5)  btn_n = 1'b1;
            if (ec < 125 && ec % 20 == 15) btn_n = 1'b0;
            if (ec == 125) btn_n = 1'b1;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 20'd0) begin
            n_fail++;
            $display("FAIL midpress_reset actual=%h required=0", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            n_checks++;
            if ({n, move_count} !== {(ec == 7), (ec >= 7) ? 8'd1 : 8'd0}) begin
                n_fail++;
                $display("FAIL midpress_repulse ec=%0d actual=%b/%0d required=%b", ec, n,
                         move_count, (ec == 7));
            end
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL midpress_model ec=%0d actual=%h required=%h", ec, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        int r;
        logic [3:0] btns;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random_model ec=%0d actual=%h required=%h", ec, obs, expv);
            end
            n_checks++;
            if ($countones({n, s, e, w}) > 1) begin
                n_fail++;
                $display("FAIL random_onehot ec=%0d actual=%b required=at most one", ec,
                         {n, s, e, w});
            end
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                if (r < 4)      btns = 4'd0;
                else if (r < 8) btns = 4'b0001 << $urandom_range(0, 3);
                else            btns = 4'($urandom);
                {btn_w, btn_e, btn_s, btn_n} = btns;
                hold = $urandom_range(1, 14);
                if ($urandom_range(0, 15) == 0) game_over = ~game_over;
            end else begin
                hold--;
            end
        end
    endtask

    initial begin
        test_reset();
        test_north_latency();
        test_bounce();
        test_conflict();
        test_back_to_back();
        test_game_over();
        test_saturation_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
